// File: rtl/keypad_conditioner.sv
// Keypad input conditioning: per-line synchroniser and debouncer, rise detection,
// and single-cycle press pulses. Digit pulses are one-hot or zero, with multi-press lockout.
module keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_digit_i,
  input  logic       raw_confirm_i,
  input  logic       raw_shuffle_i,
  output logic [9:0] digit_buttons,
  output logic       confirm_button,
  output logic       shuffle_button,
  output logic [11:0] stable_o,
  output logic       multi_press_o
);

  localparam int NL    = 12;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic more_than_one(input logic [9:0] v);
    return |(v & (v - 10'd1));
  endfunction

  logic [NL-1:0]    raw_p0;
  logic [NL-1:0]    sync_p1 [SYNC_STAGES];
  logic [NL-1:0]    sync;
  logic [CNT_W-1:0] cnt_p2 [NL];
  logic [NL-1:0]    stable_p2;
  logic [NL-1:0]    stable_nxt;
  logic [NL-1:0]    rise;
  logic             multi_p2;
  logic             multi_nxt;
  logic             multi_set;
  logic [NL-1:0]    pend_p3;

  assign raw_p0 = {raw_shuffle_i, raw_confirm_i, raw_digit_i};
  assign sync   = sync_p1[SYNC_STAGES-1];

  always_comb begin
    stable_nxt = stable_p2;
    for (int b = 0; b < NL; b++) begin
      if (sync[b] != stable_p2[b] && cnt_p2[b] == CNT_LAST) stable_nxt[b] = sync[b];
    end
  end

  assign rise      = stable_nxt & ~stable_p2;
  // Any digit rise that leaves two or more digits held is ambiguous.
  assign multi_set = (|rise[9:0]) && more_than_one(stable_nxt[9:0]);

  always_comb begin
    multi_nxt = multi_p2;
    if (multi_set) multi_nxt = 1'b1;
    if (stable_nxt[9:0] == 10'd0) multi_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p1[s] <= '0;
      for (int b = 0; b < NL; b++) cnt_p2[b] <= '0;
      stable_p2      <= '0;
      multi_p2       <= 1'b0;
      pend_p3        <= '0;
      digit_buttons  <= '0;
      confirm_button <= 1'b0;
      shuffle_button <= 1'b0;
    end else begin
      // p1: synchroniser chain
      sync_p1[0] <= raw_p0;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p1[s] <= sync_p1[s-1];
      // p2: debounce counters, debounced level and lockout flag
      for (int b = 0; b < NL; b++) begin
        if (sync[b] == stable_p2[b] || cnt_p2[b] == CNT_LAST) cnt_p2[b] <= '0;
        else cnt_p2[b] <= cnt_p2[b] + CNT_W'(1);
      end
      stable_p2 <= stable_nxt;
      multi_p2  <= multi_nxt;
      // p3: pulse decision; confirm wins over a same-edge shuffle
      pend_p3[9:0] <= (multi_set || multi_p2) ? 10'd0 : rise[9:0];
      pend_p3[10]  <= rise[10];
      pend_p3[11]  <= rise[11] & ~rise[10];
      // p4: registered pulse outputs
      digit_buttons  <= pend_p3[9:0];
      confirm_button <= pend_p3[10];
      shuffle_button <= pend_p3[11];
    end
  end

  assign stable_o      = stable_p2;
  assign multi_press_o = multi_p2;

endmodule
